fetch_stage: RTL and testbench

//  Instruction fetch stage: owns the PC and drives the instruction-memory request (imemREN/imemaddr).

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 42 ++++
 rtl/fetch_stage.sv | 153 +++++++++++++++
 tb/tb_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types and constants for the instruction fetch stage.
// Holds the machine word type, the fetch FSM state encoding, the default
// sequential PC increment, and a small helper that word-aligns an address.
package fetch_stage_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam int unsigned PC_STEP_DEFAULT = 4;

   // Clear the two byte-offset bits so the address points at a whole word.
   function automatic word_t alignPc(input word_t pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-memory port and the IF/ID
// valid/ready handshake. The fetch stage uses the master view; the memory
// and decode side use the slave view.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;

   logic  instr_valid;
   logic  dec_ready;
   word_t instr;
   word_t instr_pc;
   word_t instr_npc;

   modport master (
      output imemREN,
      output imemaddr,
      input  ihit,
      input  imemload,
      output instr_valid,
      input  dec_ready,
      output instr,
      output instr_pc,
      output instr_npc
   );

   modport slave (
      input  imemREN,
      input  imemaddr,
      output ihit,
      output imemload,
      input  instr_valid,
      output dec_ready,
      input  instr,
      input  instr_pc,
      input  instr_npc
   );

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage. Owns the PC, issues instruction
// memory reads, latches the returned word and offers it to decode through a
// valid/ready handshake. Accepts redirects and a sticky halt.
// Optional feature macro: FETCH_ALIGN_CHECK_EN -- when defined, a redirect to
// a non-word-aligned target halts the stage and raises a sticky
// misalign_fault; when undefined the target's low two bits are dropped.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word_t       PC0     = 32'h0000_0000,
   parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
   input  logic          CLK,
   input  logic          nRST,
   fetch_stage_if.master bus,
   input  logic          redirect_valid,
   input  word_t         redirect_pc,
   input  logic          halt,
   output logic          halted,
   output logic          misalign_fault
);

   fetch_state_t state;
   fetch_state_t nextState;

   word_t pc;
   word_t instrReg;
   word_t instrPcReg;
   word_t instrNpcReg;
   logic  instrValidReg;

   logic  redirectBad;
   word_t redirectTarget;
   logic  handshake;
   logic  inFetch;
   logic  inHold;
   logic  active;

   // A redirect to a misaligned target either becomes a fault or is
   // silently word-aligned, depending on the build.
`ifdef FETCH_ALIGN_CHECK_EN
   assign redirectBad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign redirectTarget = redirect_pc;
`else
   assign redirectBad    = 1'b0;
   assign redirectTarget = alignPc(redirect_pc);
`endif

   assign inFetch   = (state == FETCH);
   assign inHold    = (state == HOLD);
   assign active    = (state != HALTED);
   assign handshake = instrValidReg && bus.dec_ready;

   // State register: reset puts the stage back at the start of a fetch.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= FETCH;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: halt beats redirect, redirect beats a memory hit,
   // and a hit beats the decode handshake. HALTED is left only by reset.
   always_comb begin
      nextState = state;
      case (state)
         FETCH: begin
            if (halt || redirectBad) begin
               nextState = HALTED;
            end else if (redirect_valid) begin
               nextState = FETCH;
            end else if (bus.ihit) begin
               nextState = HOLD;
            end
         end
         HOLD: begin
            if (halt || redirectBad) begin
               nextState = HALTED;
            end else if (redirect_valid) begin
               nextState = FETCH;
            end else if (handshake) begin
               nextState = FETCH;
            end
         end
         HALTED: begin
            nextState = HALTED;
         end
         default: begin
            nextState = FETCH;
         end
      endcase
   end

   // PC and IF/ID latch: capture the returned word on a hit, advance the PC
   // when decode takes it, and squash the latched word on redirect or halt.
   // A handshake coinciding with a redirect still retires the instruction,
   // but the PC follows the redirect target.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc            <= PC0;
         instrReg      <= '0;
         instrPcReg    <= '0;
         instrNpcReg   <= '0;
         instrValidReg <= 1'b0;
      end else if (active) begin
         if (halt || redirectBad) begin
            instrValidReg <= 1'b0;
         end else if (redirect_valid) begin
            pc            <= redirectTarget;
            instrValidReg <= 1'b0;
         end else if (inFetch && bus.ihit) begin
            instrReg      <= bus.imemload;
            instrPcReg    <= pc;
            instrNpcReg   <= pc + word_t'(PC_STEP);
            instrValidReg <= 1'b1;
         end else if (inHold && handshake) begin
            pc            <= instrNpcReg;
            instrValidReg <= 1'b0;
         end
      end
   end

   // Misalignment fault: set once by a bad redirect and held until reset.
`ifdef FETCH_ALIGN_CHECK_EN
   logic misalignReg;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         misalignReg <= 1'b0;
      end else if (active && !halt && redirectBad) begin
         misalignReg <= 1'b1;
      end
   end

   assign misalign_fault = misalignReg;
`else
   assign misalign_fault = 1'b0;
`endif

   // Outputs: the read request is live only while fetching and never while
   // reset is asserted, so an in-flight request drops the moment nRST falls.
   always_comb begin
      bus.imemREN     = nRST && inFetch;
      bus.imemaddr    = pc;
      bus.instr_valid = instrValidReg;
      bus.instr       = instrReg;
      bus.instr_pc    = instrPcReg;
      bus.instr_npc   = instrNpcReg;
      halted          = (state == HALTED);
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed-vector scoreboard bench for fetch_stage.
// Expected instructions are queued as stimulus issues memory hits; a monitor
// pops and compares them whenever decode accepts an instruction.
// Honours FETCH_ALIGN_CHECK_EN for the misaligned-redirect case.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t npc;
   } expect_t;

   logic  CLK;
   logic  nRST;
   logic  redirect_valid;
   word_t redirect_pc;
   logic  halt;
   logic  halted;
   logic  misalign_fault;

   int compared;
   int mismatched;

   expect_t expQ[$];

   fetch_stage_if bus();

   fetch_stage #(
      .PC0     (32'h0000_0000),
      .PC_STEP (4)
   ) dut (
      .CLK            (CLK),
      .nRST           (nRST),
      .bus            (bus.master),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halted         (halted),
      .misalign_fault (misalign_fault)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Instruction memory contents: a recognisable tag plus the low address bits.
   function automatic word_t memWord(input word_t addr);
      return {16'hC0DE, addr[15:0]};
   endfunction

   assign bus.imemload = memWord(bus.imemaddr);

   task automatic checkOutput(input string name, input word_t actual, input word_t expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ihitIn, input logic readyIn,
                                input logic redirIn, input word_t redirPcIn,
                                input logic haltIn);
      bus.ihit       = ihitIn;
      bus.dec_ready  = readyIn;
      redirect_valid = redirIn;
      redirect_pc    = redirPcIn;
      halt           = haltIn;
   endtask

   task automatic pushExp(input word_t addr);
      expect_t e;
      e.instr = memWord(addr);
      e.pc    = addr;
      e.npc   = addr + 32'd4;
      expQ.push_back(e);
   endtask

   // One full fetch at addr with decode ready; entered and left at posedge+1.
   task automatic fetchOne(input word_t addr);
      pushExp(addr);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
      checkOutput("fetch addr", bus.imemaddr, addr);
      checkOutput("fetch ren", 32'(bus.imemREN), 32'd1);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge CLK); #1;
   endtask

   // Monitor: every accepted instruction must match the oldest expectation.
   initial begin
      expect_t e;
      forever begin
         @(negedge CLK);
         if (nRST && bus.instr_valid && bus.dec_ready) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected instr: got pc 0x%08h instr 0x%08h expected none",
                        bus.instr_pc, bus.instr);
            end else begin
               e = expQ.pop_front();
               checkOutput("instr", bus.instr, e.instr);
               checkOutput("instr_pc", bus.instr_pc, e.pc);
               checkOutput("instr_npc", bus.instr_npc, e.npc);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] timeout");
   end

   // Directed stimulus sequence.
   initial begin
      compared   = 0;
      mismatched = 0;
      nRST       = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

      $display("[TB] reset state");
      @(negedge CLK);
      checkOutput("rst ren", 32'(bus.imemREN), 32'd0);
      checkOutput("rst addr", bus.imemaddr, 32'h0);
      checkOutput("rst valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("rst instr", bus.instr, 32'h0);
      checkOutput("rst halted", 32'(halted), 32'd0);
      checkOutput("rst misalign", 32'(misalign_fault), 32'd0);
      @(posedge CLK); #1;
      nRST = 1'b1;

      $display("[TB] sequential fetch");
      for (int i = 0; i < 4; i++) begin
         fetchOne(word_t'(i * 4));
      end

      $display("[TB] delayed ihit and backpressure at 0x10");
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checkOutput("wait addr", bus.imemaddr, 32'h10);
         checkOutput("wait valid", 32'(bus.instr_valid), 32'd0);
         @(posedge CLK); #1;
      end
      pushExp(32'h10);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
      checkOutput("hit cycle valid", 32'(bus.instr_valid), 32'd0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         checkOutput("bp valid", 32'(bus.instr_valid), 32'd1);
         checkOutput("bp instr", bus.instr, 32'hC0DE_0010);
         checkOutput("bp instr_pc", bus.instr_pc, 32'h10);
         checkOutput("bp ren", 32'(bus.imemREN), 32'd0);
         checkOutput("bp pc", bus.imemaddr, 32'h10);
         @(posedge CLK); #1;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge CLK); #1;

      fetchOne(32'h14);
      fetchOne(32'h18);
      fetchOne(32'h1C);

      $display("[TB] redirect with ihit at 0x20");
      @(negedge CLK);
      checkOutput("pre-redirect addr", bus.imemaddr, 32'h20);
      @(posedge CLK); #1;
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h100, 1'b0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
      checkOutput("redir valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("redir addr", bus.imemaddr, 32'h100);
      checkOutput("redir ren", 32'(bus.imemREN), 32'd1);
      @(posedge CLK); #1;
      fetchOne(32'h100);

      $display("[TB] redirect with handshake at 0x104");
      pushExp(32'h104);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h200, 1'b0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
      checkOutput("redir+hs addr", bus.imemaddr, 32'h200);
      checkOutput("redir+hs valid", 32'(bus.instr_valid), 32'd0);
      @(posedge CLK); #1;

      $display("[TB] PC wrap");
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      fetchOne(32'hFFFF_FFFC);
      @(negedge CLK);
      checkOutput("wrap addr", bus.imemaddr, 32'h0);
      @(posedge CLK); #1;

      $display("[TB] halt during fetch");
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      @(posedge CLK); #1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
         @(negedge CLK);
         checkOutput("halt halted", 32'(halted), 32'd1);
         checkOutput("halt ren", 32'(bus.imemREN), 32'd0);
         checkOutput("halt valid", 32'(bus.instr_valid), 32'd0);
         @(posedge CLK); #1;
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      nRST = 1'b0;
      @(negedge CLK);
      checkOutput("rst2 ren", 32'(bus.imemREN), 32'd0);
      checkOutput("rst2 addr", bus.imemaddr, 32'h0);
      checkOutput("rst2 halted", 32'(halted), 32'd0);
      checkOutput("rst2 valid", 32'(bus.instr_valid), 32'd0);
      checkOutput("rst2 instr_pc", bus.instr_pc, 32'h0);
      checkOutput("rst2 instr_npc", bus.instr_npc, 32'h0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(negedge CLK);
      checkOutput("post-rst addr", bus.imemaddr, 32'h0);
      checkOutput("post-rst ren", 32'(bus.imemREN), 32'd1);
      @(posedge CLK); #1;

      $display("[TB] misaligned redirect");
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h102, 1'b0);
      @(posedge CLK); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge CLK);
`ifdef FETCH_ALIGN_CHECK_EN
      checkOutput("misalign fault", 32'(misalign_fault), 32'd1);
      checkOutput("misalign halted", 32'(halted), 32'd1);
      checkOutput("misalign ren", 32'(bus.imemREN), 32'd0);
      checkOutput("misalign pc", bus.imemaddr, 32'h0);
      @(posedge CLK); #1;
`else
      checkOutput("align addr", bus.imemaddr, 32'h100);
      checkOutput("align fault", 32'(misalign_fault), 32'd0);
      checkOutput("align halted", 32'(halted), 32'd0);
      @(posedge CLK); #1;
      fetchOne(32'h100);
`endif

      repeat (2) @(posedge CLK);
      checkOutput("scoreboard drained", word_t'(expQ.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
